i2c_target: RTL and testbench

Parametrised I2C target (slave) running entirely in the system clock domain, successor to the SCL-clocked slave. It oversamples and glitch-filters SCL/SDA, recognises START, repeated START and STOP, and matches a parametrised 7-bit address. It exposes a byte-wide register-file port with an auto-incrementing register pointer and supports both write and read transactions. It sits between the board's open-drain I2C pins (external tri-state buffer) and a local register bank.

---
 rtl/i2c_target.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target in the system clock domain: synchronised, glitch-filtered SCL/SDA, 7-bit address
// match and a byte-wide register port with an auto-incrementing, wrapping pointer.
module i2c_target #(
  parameter logic [6:0]  ADDRESS     = 7'h42,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic              wr_en_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic              rd_en_o,
  output logic              busy_o
);

  localparam int unsigned    CntW   = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  // Line index 0 is SCL, 1 is SDA.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]                  flt_q, flt_d, prev_q;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                rw_q, rw_d;
  logic [REG_AW-1:0]   ptr_q, ptr_d;
  logic                oe_q, oe_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;

  logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, last_bit, load_rd;
  logic [7:0] rx_byte;

  assign raw = {sda_i, scl_i};

  // A filtered line only follows its synchroniser after FILTER_LEN consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      flt_d[i]  = flt_q[i];
      cnt_d[i]  = '0;
      if (sync_q[i][SYNC_STAGES-1] != flt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          flt_d[i] = sync_q[i][SYNC_STAGES-1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f     = flt_q[0];
  assign sda_f     = flt_q[1];
  assign scl_rise  = scl_f & ~prev_q[0];
  assign scl_fall  = ~scl_f & prev_q[0];
  assign start_det = ~sda_f & prev_q[1] & scl_f & prev_q[0];
  assign stop_det  = sda_f & ~prev_q[1] & scl_f & prev_q[0];
  assign last_bit  = (bit_cnt_q == 4'd7);
  assign rx_byte   = {shift_q[6:0], sda_f};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    load_rd   = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (shift_q[6:0] == ADDRESS) begin
                state_d = StAddrAck;
                rw_d    = sda_f;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              ptr_d     = rx_byte[REG_AW-1:0];
              state_d   = StPtrAck;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_q + 1'b1;
              state_d   = StWrAck;
            end
          end
        end
        // ACK is always driven, so oe_q tells the first fall (start ACK) from the second (end).
        StAddrAck, StPtrAck, StWrAck: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                load_rd = 1'b1;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StRdData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdAck;
            end else begin
              oe_d      = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // bit_cnt_q marks whether the master's ACK has already been seen in this slot.
        StRdAck: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (!sda_f) begin
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            load_rd = 1'b1;
          end
        end
        StIdle, StIgnore: begin
        end
        default: state_d = StIdle;
      endcase

      if (load_rd) begin
        shift_d   = rd_data_i;
        rd_en_d   = 1'b1;
        oe_d      = ~rd_data_i[7];
        bit_cnt_d = 4'd1;
        state_d   = StRdData;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      flt_q     <= 2'b11;
      prev_q    <= 2'b11;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      flt_q     <= flt_d;
      prev_q    <= flt_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe_o  = oe_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = ptr_q;
  assign rd_en_o   = rd_en_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus master with open-drain SDA, a register bank on the port side,
// and a transaction-level memory/pointer model that predicts writes and read data.
module tb_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, rd_en, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe_o (sda_oe),
    .wr_en_o  (wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .rd_addr_o(rd_addr),
    .rd_data_i(rd_data),
    .rd_en_o  (rd_en),
    .busy_o   (busy)
  );

  // Register bank seen by the target; reloaded with a known pattern on reset.
  logic [7:0] bank [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank[i] <= 8'(i * 29 + 7);
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
    rd_data <= bank[rd_addr];
  end

  // Strobe monitor.
  logic [11:0] wr_obs[$];
  int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, pulse_err = 0;
  logic wr_en_d1 = 1'b0, rd_en_d1 = 1'b0;
  always @(negedge clk) begin
    if (wr_en) begin
      wr_obs.push_back({wr_addr, wr_data});
      wr_cnt++;
    end
    if (rd_en) rd_cnt++;
    if ((wr_en && wr_en_d1) || (rd_en && rd_en_d1)) pulse_err++;
    if (sda_oe) oe_cnt++;
    wr_en_d1 = wr_en;
    rd_en_d1 = rd_en;
  end

  // Reference model.
  logic [7:0]  mem_m [16];
  logic [3:0]  ptr_m;
  logic [11:0] exp_wr[$];
  logic [7:0]  wq[$];

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'(i * 29 + 7);
    ptr_m = 4'd0;
    exp_wr.delete();
    wr_obs.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    tick(Q);
    if (!scl_m) begin
      scl_m = 1'b1;
      tick(Q);
    end
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(2 * Q);
  endtask

  // g: 0 clean, 1 two-clk SCL low glitch, 2 two-clk SDA spike, both while SCL is high.
  task automatic clk_bit(input logic b, input int g, output logic r);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q - 4);
    if (g == 1) begin
      scl_m = 1'b0;
      tick(2);
      scl_m = 1'b1;
    end else if (g == 2) begin
      sda_m = ~b;
      tick(2);
      sda_m = b;
    end else begin
      tick(2);
    end
    tick(2);
    r = sda_line;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] gscl, input logic [7:0] gsda,
                           output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], gscl[i] ? 1 : (gsda[i] ? 2 : 0), r);
    clk_bit(1'b1, 0, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 0, r);
      d[i] = r;
    end
    clk_bit(nack, 0, r);
  endtask

  // Write transaction: pointer p, data taken from wq, then trunc stray bits before STOP.
  task automatic tx_write(input logic [7:0] p, input int trunc, input logic glitch);
    logic       a, r;
    logic [7:0] d;
    int         n;
    n = wq.size();
    bus_start();
    send_byte(8'h84, 8'h00, 8'h00, a);
    check("wr_addr_ack", 32'(a), 32'd1);
    send_byte(p, 8'h00, 8'h00, a);
    check("ptr_ack", 32'(a), 32'd1);
    ptr_m = p[3:0];
    for (int k = 0; k < n; k++) begin
      d = wq.pop_front();
      send_byte(d, (glitch && k == 0) ? 8'h08 : 8'h00, (glitch && k < 2) ? 8'h20 : 8'h00, a);
      check("data_ack", 32'(a), 32'd1);
      exp_wr.push_back({ptr_m, d});
      mem_m[ptr_m] = d;
      ptr_m = ptr_m + 4'd1;
    end
    for (int k = 0; k < trunc; k++) clk_bit(1'($urandom_range(0, 1)), 0, r);
    check("busy_on", 32'(busy), 32'd1);
    bus_stop();
    check("busy_off", 32'(busy), 32'd0);
    check("wr_count", 32'(wr_obs.size()), 32'(exp_wr.size()));
    while (wr_obs.size() > 0 && exp_wr.size() > 0)
      check("wr_strobe", 32'(wr_obs.pop_front()), 32'(exp_wr.pop_front()));
    wr_obs.delete();
    exp_wr.delete();
  endtask

  task automatic tx_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] d;
    int         rd0;
    rd0 = rd_cnt;
    if (set_ptr) begin
      bus_start();
      send_byte(8'h84, 8'h00, 8'h00, a);
      check("rd_waddr_ack", 32'(a), 32'd1);
      send_byte(p, 8'h00, 8'h00, a);
      check("rd_ptr_ack", 32'(a), 32'd1);
      ptr_m = p[3:0];
    end
    bus_start();
    send_byte(8'h85, 8'h00, 8'h00, a);
    check("rd_addr_ack", 32'(a), 32'd1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, d);
      check("rd_data", 32'(d), 32'(mem_m[ptr_m]));
      if (k < n - 1) ptr_m = ptr_m + 4'd1;
    end
    check("sda_released", 32'(sda_oe), 32'd0);
    check("rd_en_count", 32'(rd_cnt - rd0), 32'(n));
    bus_stop();
    check("rd_busy_off", 32'(busy), 32'd0);
  endtask

  task automatic tx_bad(input logic [6:0] adr, input logic do_stop);
    logic a;
    int   o0, w0;
    o0 = oe_cnt;
    w0 = wr_cnt;
    bus_start();
    send_byte({adr, 1'($urandom_range(0, 1))}, 8'h00, 8'h00, a);
    check("bad_addr_nack", 32'(a), 32'd0);
    send_byte(8'($urandom), 8'h00, 8'h00, a);
    check("bad_byte_nack", 32'(a), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    check("bad_oe_cycles", 32'(oe_cnt - o0), 32'd0);
    check("bad_wr_strobes", 32'(wr_cnt - w0), 32'd0);
    if (do_stop) bus_stop();
  endtask

  initial begin
    logic r;
    logic [7:0] b;
    int op;
    logic [6:0] ba;

    model_reset();
    tick(4);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({wr_en, rd_en}), 32'd0);
    check("rst_wr_bus", 32'({wr_addr, wr_data}), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    tick(10);

    // Plain write of two bytes.
    wq.push_back(8'hA5);
    wq.push_back(8'h5A);
    tx_write(8'h03, 0, 1'b0);

    // Random read across the pointer wrap.
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    tx_write(8'h0F, 0, 1'b0);
    tx_read(1'b1, 8'h0F, 2);

    // Address mismatch, then a repeated START to the right address.
    tx_bad(7'h48, 1'b0);
    wq.push_back(8'h77);
    tx_write(8'h08, 0, 1'b0);

    // Glitches on both lines while SCL is high.
    wq.push_back(8'h3C);
    wq.push_back(8'hC3);
    tx_write(8'h0A, 0, 1'b1);
    tx_read(1'b1, 8'h0A, 2);

    // Truncated write leaves the pointer at 5.
    tx_write(8'h05, 4, 1'b0);
    tx_read(1'b0, 8'h00, 1);

    // Reset during the address ACK.
    bus_start();
    b = 8'h84;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 0, r);
    check("ack_drive", 32'(sda_oe), 32'd1);
    check("ack_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    sda_m = 1'b1;
    tick(10);
    bus_stop();
    model_reset();
    wq.push_back(8'h96);
    wq.push_back(8'h69);
    tx_write(8'h0E, 0, 1'b0);
    tx_read(1'b1, 8'h0E, 3);

    // Randomised traffic.
    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) wq.push_back(8'($urandom));
        tx_write(8'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 7) : 0, 1'b0);
      end else if (op == 1) begin
        tx_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3));
      end else begin
        ba = 7'($urandom);
        if (ba == 7'h42) ba = 7'h43;
        tx_bad(ba, 1'b1);
      end
    end

    check("strobe_width", 32'(pulse_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
